// File: rtl/i2s_pkg.sv
// Shared types and default constants for the I2S frame controller slice.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } i2s_state_t;

    localparam int unsigned I2S_DW         = 24;
    localparam int unsigned I2S_SCLK_DIV   = 4;
    localparam int unsigned I2S_FRAME_BITS = 32;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit clock / word select generator: divides clk into sclk and counts
// sclk periods across a stereo frame to produce lrclk and a frame_wrap strobe.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int unsigned SCLK_DIV   = I2S_SCLK_DIV,
    parameter int unsigned FRAME_BITS = I2S_FRAME_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic sclk,
    output logic lrclk,
    output logic frame_wrap
);

    localparam int unsigned DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(2 * FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(FRAME_BITS);

    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic             lrclk_q, lrclk_d;

    // Last clk of the last sclk period in the frame: the next falling edge wraps bit_cnt.
    assign frame_wrap = (div_q == DIV_LAST) && (bit_q == BIT_LAST);

    assign sclk  = sclk_q;
    assign lrclk = lrclk_q;

    // Next counter values; sclk/lrclk are decoded from the next counts so the
    // registered outputs line up with the counters they describe.
    always_comb begin
        div_d   = div_q;
        bit_d   = bit_q;
        sclk_d  = 1'b0;
        lrclk_d = 1'b1;
        if (run) begin
            if (clear) begin
                div_d = '0;
                bit_d = '0;
            end else if (div_q == DIV_LAST) begin
                div_d = '0;
                bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            sclk_d  = (div_d >= DIV_HALF);
            lrclk_d = (bit_d >= BIT_HALF);
        end else begin
            div_d = '0;
            bit_d = '0;
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            lrclk_q <= lrclk_d;
        end
    end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S stream controller: start/stop on frame boundaries, FWFT FIFO service
// for i2s_tx sample requests, silence substitution and underrun counting.
module i2s_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int unsigned DW         = I2S_DW,
    parameter int unsigned SCLK_DIV   = I2S_SCLK_DIV,
    parameter int unsigned FRAME_BITS = I2S_FRAME_BITS,
    parameter int unsigned UCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DW-1:0]     fifo_l,
    input  logic [DW-1:0]     fifo_r,
    output logic              fifo_rd_en,
    input  logic              tx_rd_en,
    output logic              tx_rd_valid,
    output logic [DW-1:0]     tx_l_sample,
    output logic [DW-1:0]     tx_r_sample,
    output logic              sclk,
    output logic              lrclk,
    output logic              running,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt,
    input  logic              underrun_clr
);

    i2s_state_t state_q, state_d;

    logic              frame_wrap;
    logic              gen_run;
    logic              gen_clear;
    logic              svc;
    logic              ur_hit;

    logic              valid_q, valid_d;
    logic [DW-1:0]     l_q, l_d;
    logic [DW-1:0]     r_q, r_d;
    logic              ur_q, ur_d;
    logic [UCNT_W-1:0] cnt_q, cnt_d;

    // The generator follows the next state so that the stop edge lands the
    // counters directly in their idle values (lrclk=1, sclk=0) without a glitch.
    assign gen_run   = (state_d != IDLE);
    assign gen_clear = (state_q == IDLE) && (state_d == RUN);

    i2s_clk_gen #(
        .SCLK_DIV   (SCLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (gen_run),
        .clear      (gen_clear),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .frame_wrap (frame_wrap)
    );

    assign running    = (state_q != IDLE);
    assign svc        = tx_rd_en && running;
    assign fifo_rd_en = svc && !fifo_empty;
    assign ur_hit     = svc && fifo_empty;

    assign tx_rd_valid  = valid_q;
    assign tx_l_sample  = l_q;
    assign tx_r_sample  = r_q;
    assign underrun     = ur_q;
    assign underrun_cnt = cnt_q;

    // Stream FSM next state; re-enable while stopping wins over the frame wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (enable && !fifo_empty) state_d = RUN;
            RUN:      if (!enable) state_d = STOPPING;
            STOPPING: begin
                if (enable)          state_d = RUN;
                else if (frame_wrap) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Sample handshake and underrun accounting; clear beats a coincident increment.
    always_comb begin
        valid_d = svc;
        ur_d    = ur_hit;
        l_d     = l_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        if (svc) begin
            l_d = fifo_empty ? '0 : fifo_l;
            r_d = fifo_empty ? '0 : fifo_r;
        end
        if (underrun_clr) begin
            cnt_d = '0;
        end else if (ur_hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + UCNT_W'(1);
        end
    end

    // State and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            ur_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            l_q     <= l_d;
            r_q     <= r_d;
            ur_q    <= ur_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Randomized bench for i2s_frame_ctrl against a time-based reference model.
module tb_i2s_frame_ctrl;

    localparam int unsigned DW    = 24;
    localparam int unsigned SD    = 4;
    localparam int unsigned FB    = 32;
    localparam int unsigned UW    = 2;
    localparam int unsigned FRAME = 2 * FB * SD;
    localparam int unsigned HALF  = FB * SD;
    localparam int unsigned UMAX  = (1 << UW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_l, fifo_r;
    logic          fifo_rd_en;
    logic          tx_rd_en;
    logic          tx_rd_valid;
    logic [DW-1:0] tx_l_sample, tx_r_sample;
    logic          sclk, lrclk, running, underrun;
    logic [UW-1:0] underrun_cnt;
    logic          underrun_clr;

    always #5 clk = ~clk;

    i2s_frame_ctrl #(
        .DW         (DW),
        .SCLK_DIV   (SD),
        .FRAME_BITS (FB),
        .UCNT_W     (UW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_l       (fifo_l),
        .fifo_r       (fifo_r),
        .fifo_rd_en   (fifo_rd_en),
        .tx_rd_en     (tx_rd_en),
        .tx_rd_valid  (tx_rd_valid),
        .tx_l_sample  (tx_l_sample),
        .tx_r_sample  (tx_r_sample),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .running      (running),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .underrun_clr (underrun_clr)
    );

    int errors = 0;
    int checks = 0;

    // FIFO contents (model-owned) and reference state.
    logic [DW-1:0] ql[$];
    logic [DW-1:0] qr[$];
    int            m_mode;   // 0 silent, 1 playing, 2 playing out the last frame
    int unsigned   m_t;      // clk cycles since the current stream started
    bit            m_valid, m_ur;
    logic [DW-1:0] m_l, m_r;
    int unsigned   m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_valid = 0; m_ur = 0;
        m_l = '0; m_r = '0; m_cnt = 0;
    endtask

    task automatic check_outputs(input bit tx);
        bit act;
        bit empty;
        act   = (m_mode != 0);
        empty = (ql.size() == 0);
        check("running",      running,      act);
        check("sclk",         sclk,         act ? ((m_t % SD) >= SD / 2) : 1'b0);
        check("lrclk",        lrclk,        act ? ((m_t % FRAME) >= HALF) : 1'b1);
        check("fifo_rd_en",   fifo_rd_en,   act && tx && !empty);
        check("tx_rd_valid",  tx_rd_valid,  m_valid);
        check("tx_l_sample",  tx_l_sample,  m_l);
        check("tx_r_sample",  tx_r_sample,  m_r);
        check("underrun",     underrun,     m_ur);
        check("underrun_cnt", underrun_cnt, m_cnt);
    endtask

    task automatic model_step(input bit en, input bit tx, input bit clr);
        bit act;
        bit empty;
        act   = (m_mode != 0);
        empty = (ql.size() == 0);
        if (act && tx) begin
            m_valid = 1;
            m_ur    = empty;
            if (empty) begin
                m_l = '0; m_r = '0;
            end else begin
                m_l = ql.pop_front();
                m_r = qr.pop_front();
            end
        end else begin
            m_valid = 0;
            m_ur    = 0;
        end
        if (clr) m_cnt = 0;
        else if (act && tx && empty && m_cnt < UMAX) m_cnt++;
        case (m_mode)
            0: if (en && !empty) begin m_mode = 1; m_t = 0; end
            1: begin m_t++; if (!en) m_mode = 2; end
            default: begin
                if (en) begin m_mode = 1; m_t++; end
                else if ((m_t % FRAME) == FRAME - 1) begin m_mode = 0; m_t = 0; end
                else m_t++;
            end
        endcase
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cycle(input bit en, input bit tx, input bit clr, input bit push);
        if (push) begin
            ql.push_back(DW'($urandom));
            qr.push_back(DW'($urandom));
        end
        enable       = en;
        tx_rd_en     = tx;
        underrun_clr = clr;
        fifo_empty   = (ql.size() == 0);
        fifo_l       = fifo_empty ? DW'($urandom) : ql[0];
        fifo_r       = fifo_empty ? DW'($urandom) : qr[0];
        @(negedge clk);
        check_outputs(tx);
        @(posedge clk);
        model_step(en, tx, clr);
        #1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; tx_rd_en = 1'b0; underrun_clr = 1'b0;
        fifo_empty = 1'b1; fifo_l = '0; fifo_r = '0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_outputs(1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Preloaded FIFO, start, one request for the known head pair.
        ql.push_back(24'hABCDEF); qr.push_back(24'h123456);
        ql.push_back(DW'($urandom)); qr.push_back(DW'($urandom));
        ql.push_back(DW'($urandom)); qr.push_back(DW'($urandom));
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 300; i++) cycle(1, 0, 0, 0);

        // Drain the FIFO, then underruns up to saturation and a coincident clear.
        for (int i = 0; i < 7; i++) begin
            cycle(1, 1, 0, 0);
            cycle(1, 0, 0, 0);
        end
        cycle(1, 1, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);

        // Drop enable at bit 10 and let the frame finish.
        for (int i = 0; i < 600 && (m_t % FRAME) != 10 * SD; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 600 && m_mode != 0; i++) cycle(0, 0, 0, 0);
        check("stop_to_idle", running, 1'b0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

        // Enable with an empty FIFO stays idle until the first write.
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 0);
        check("start_after_write", running, 1'b1);

        // Drop at bit 10, re-enable at bit 40: no gap in the frame.
        for (int i = 0; i < 600 && (m_t % FRAME) != 10 * SD; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 600 && (m_t % FRAME) != 40 * SD; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 600; i++) cycle(1, 0, 0, 0);

        // Random traffic.
        begin
            bit en;
            en = 1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 299) == 0) en = ~en;
                cycle(en, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
                      (ql.size() < 8) && ($urandom_range(0, 3) == 0));
            end
        end

        // Asynchronous reset mid-frame with live outputs.
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
        for (int i = 0; i < 900 && !(m_mode == 1 && (m_t % FRAME) > 20 && (m_t % FRAME) < 100); i++)
            cycle(1, 0, 0, 1);
        cycle(1, 1, 0, 0);
        rst = 1'b1;
        #1;
        check("arst_running",  running,      1'b0);
        check("arst_sclk",     sclk,         1'b0);
        check("arst_lrclk",    lrclk,        1'b1);
        check("arst_valid",    tx_rd_valid,  1'b0);
        check("arst_l",        tx_l_sample,  '0);
        check("arst_r",        tx_r_sample,  '0);
        check("arst_underrun", underrun,     1'b0);
        check("arst_cnt",      underrun_cnt, '0);
        model_reset();
        tx_rd_en = 1'b0;
        @(negedge clk);
        check_outputs(1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 300; i++) cycle(1, ($urandom_range(0, 5) == 0), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_frame_ctrl.md
Name: i2s_frame_ctrl

Overview:
Controller that sequences i2s_tx on the 12.288 MHz I2S clock domain.
- Generates sclk/lrclk from clk by integer division.
- Starts and stops the serial stream on frame boundaries.
- Services i2s_tx sample requests from a first-word-fall-through stereo FIFO.
- Substitutes silence on underrun and counts underrun events.

Parameters:
DW, 24, sample width per channel; matches i2s_tx DW.
SCLK_DIV, 4, clk cycles per sclk period; even, >=2.
FRAME_BITS, 32, sclk periods per channel half-frame; >=DW+1.
UCNT_W, 16, underrun counter width.

Ports:
clk  in  1  I2S-domain clock.
rst  in  1  asynchronous, active-high reset.
enable  in  1  level request to run the stream.
fifo_empty  in  1  FWFT FIFO empty flag.
fifo_l  in  DW  FIFO head, left sample; valid when !fifo_empty.
fifo_r  in  DW  FIFO head, right sample; valid when !fifo_empty.
fifo_rd_en  out  1  FIFO pop.
tx_rd_en  in  1  sample request from i2s_tx.
tx_rd_valid  out  1  sample pair valid to i2s_tx.
tx_l_sample  out  DW  left sample to i2s_tx.
tx_r_sample  out  DW  right sample to i2s_tx.
sclk  out  1  bit clock to i2s_tx and pin.
lrclk  out  1  word select; 0 = left, 1 = right.
running  out  1  high in RUN or STOPPING.
underrun  out  1  one-cycle pulse per underrun.
underrun_cnt  out  UCNT_W  saturating underrun count.
underrun_clr  in  1  synchronous clear of underrun_cnt.

Behaviour:
- Reset values:
  - state=IDLE; div_cnt=0; bit_cnt=0.
  - sclk=0, lrclk=1, running=0.
  - tx_rd_valid=0, tx_l_sample=0, tx_r_sample=0.
  - underrun=0, underrun_cnt=0.
- Reset asserted mid-frame: all of the above apply immediately, asynchronously.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - Counters held at 0; sclk=0, lrclk=1.
  - IDLE->RUN when enable && !fifo_empty (prefill guard). Enable with an empty FIFO stays IDLE.
- RUN and STOPPING:
  - div_cnt counts 0..SCLK_DIV-1 each clk.
  - sclk = (div_cnt >= SCLK_DIV/2), registered.
  - At div_cnt wrap (sclk falling edge), bit_cnt advances mod 2*FRAME_BITS.
  - lrclk = (bit_cnt >= FRAME_BITS), registered.
  - sclk and lrclk change only on sclk falling edges.
- Frame start: on the IDLE->RUN transition, div_cnt and bit_cnt are cleared, so lrclk drops 1->0 on the first RUN cycle. This is the first left-channel frame.
- RUN->STOPPING when enable=0.
- STOPPING->RUN when enable=1 again; counters are not disturbed, so there is no gap.
- STOPPING->IDLE on the falling edge where bit_cnt wraps 2*FRAME_BITS-1 -> 0.
  - lrclk stays 1 and sclk goes/stays 0.
  - No further lrclk falling edge occurs, so i2s_tx issues no further requests.
- Sample service:
  - fifo_rd_en = tx_rd_en && !fifo_empty && running (combinational, FWFT pop).
  - Cycle after tx_rd_en, tx_rd_valid=1 for exactly one cycle.
  - tx_l/r_sample carry the popped fifo_l/r, or all zeros if fifo_empty.
  - Samples are held until the next request.
- Underrun:
  - Condition: tx_rd_en && fifo_empty && running.
  - underrun pulses one cycle, aligned with tx_rd_valid.
  - underrun_cnt increments and saturates at 2^UCNT_W-1.
  - underrun_clr has priority over a simultaneous increment; the result is 0.
- tx_rd_en while not running: ignored, no valid, no pop.
- tx_rd_en on consecutive cycles: each request is serviced independently; the FIFO pops once per cycle while non-empty.

Decomposition:
- Package i2s_pkg holds:
  - enum i2s_state_t {IDLE, RUN, STOPPING}.
  - Default constants I2S_DW=24, I2S_SCLK_DIV=4, I2S_FRAME_BITS=32.
- Sub-module i2s_clk_gen:
  - Contains div_cnt, bit_cnt, sclk, lrclk, and a frame_wrap strobe.
  - Inputs: clk, rst, run, clear.
- i2s_frame_ctrl holds the FSM, the FIFO/tx handshake and the underrun logic.

Test Plan:
All scenarios use SCLK_DIV=4, FRAME_BITS=32; frame = 256 clk.
1. Reset, FIFO preloaded with (L=0xABCDEF, R=0x123456), enable=1:
   - RUN next cycle; lrclk falls on the first RUN cycle.
   - sclk period is 4 clk, with 2 high and 2 low.
   - lrclk rises after 128 clk and falls again after 256 clk.
2. tx_rd_en pulse with FIFO holding 3 pairs:
   - fifo_rd_en asserts in the same cycle.
   - Next cycle tx_rd_valid=1, tx_l_sample=0xABCDEF, tx_r_sample=0x123456.
   - FIFO count decreases to 2.
3. tx_rd_en with fifo_empty=1:
   - tx_rd_valid=1 with both samples 0; underrun pulse.
   - underrun_cnt 0->1; no fifo_rd_en.
4. enable dropped at bit_cnt=10:
   - STOPPING until bit_cnt wraps; then IDLE, lrclk=1, sclk=0, running=0.
   - Re-enable at bit_cnt=40 instead: stays running and the lrclk period stays 256.
5. enable=1 with FIFO empty:
   - Stays IDLE, lrclk=1.
   - First FIFO write moves to RUN the next cycle.
6. Force UCNT_W=2 and cause 5 underruns:
   - underrun_cnt saturates at 3.
   - underrun_clr coincident with a 6th underrun gives 0.
   - Async rst mid-frame returns all outputs to reset values immediately.
